// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between an initiator and the data memory responder
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering one request at a time after a fixed wait
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input logic            clk,
    input logic            reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic        bad;
    logic        access;
    assign idx    = addr_q[AW+1:2];
    assign bad    = addr_q[1:0] != 2'b00 || addr_q[31:AW+2] != '0;
    assign access = state == WAIT && cnt == 4'd0;
    assign bus.req_ready  = state == IDLE;
    assign bus.busy       = state != IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = state == RESP ? rdata_q : '0;
    assign bus.resp_err   = state == RESP && err_q;
    // next state: accept in IDLE, leave WAIT once the counter has run out, RESP lasts one cycle
    always_comb begin
        state_next = state == IDLE ? (bus.req_valid ? WAIT : IDLE)
                   : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
                   : IDLE;
    end
    // state register, wait counter and the latched copy of the accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.req_valid) begin
                cnt     <= 4'(WAIT_STATES);
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
    // storage access at the end of WAIT; reset clears every word and aborts a pending access
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= bad;
            rdata_q <= (bad || write_q) ? '0 : mem[idx];
            if (!bad && write_q)
                for (int b = 0; b < 4; b++)
                    if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed checks of two responders (2 and 0 wait states) against a timing/memory model
module tb_dmem_responder;
    localparam int DEPTH = 16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    bit          chk_en = 1'b0;
    int          pass = 0;
    int          total = 0;
    logic [33:0] r0, r1;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = (g == 0) ? 2 : 0;
        dmem_responder_if bus();
        assign bus.req_valid = req_valid;
        assign bus.req_write = req_write;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign bus.req_be    = req_be;
        dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
            .clk(clk), .reset(reset), .bus(bus)
        );
        // model: a request accepted at edge a is served at edge a+W+1 and frees the block at edge a+W+2
        logic [31:0] mem [DEPTH];
        bit          pend = 1'b0;
        int          n = 0;
        int          acc = 0;
        bit          c_w;
        logic [31:0] c_a, c_d;
        logic [3:0]  c_be;
        bit          e_rv = 1'b0;
        bit          e_er = 1'b0;
        logic [31:0] e_rd = '0;
        always @(posedge clk) begin
            n <= n + 1;
            e_rv <= 1'b0;
            e_er <= 1'b0;
            e_rd <= '0;
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                pend <= 1'b0;
            end else if (pend) begin
                if (n == acc + W + 1) begin
                    e_rv <= 1'b1;
                    if (c_a[1:0] != 2'b00 || c_a >= 32'(4 * DEPTH)) e_er <= 1'b1;
                    else if (!c_w) e_rd <= mem[c_a >> 2];
                    else for (int b = 0; b < 4; b++)
                        if (c_be[b]) mem[c_a >> 2][8*b +: 8] <= c_d[8*b +: 8];
                end else if (n == acc + W + 2) begin
                    pend <= 1'b0;
                end
            end else if (req_valid) begin
                pend <= 1'b1;
                acc  <= n;
                c_w  <= req_write;
                c_a  <= req_addr;
                c_d  <= req_wdata;
                c_be <= req_be;
            end
        end
        always @(negedge clk)
            if (chk_en)
                chk($sformatf("u%0d cycle %0d", g, n),
                    64'({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err, bus.resp_rdata}),
                    64'({!pend, pend, e_rv, e_er, e_rd}));
    end

    function automatic logic [31:0] raddr();
        logic [31:0] a = 32'($urandom_range(0, 19)) << 2;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a[$urandom_range(6, 31)] = 1'b1;
        return a;
    endfunction

    task automatic scramble();
        req_write = 1'($urandom);
        req_addr  = raddr();
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        scramble();
        @(negedge clk);
        r1 = {u[1].bus.resp_valid, u[1].bus.resp_err, u[1].bus.resp_rdata};
        @(negedge clk);
        @(negedge clk);
        r0 = {u[0].bus.resp_valid, u[0].bus.resp_err, u[0].bus.resp_rdata};
        @(negedge clk);
    endtask

    task automatic chk_resp(input string name, input bit err, input logic [31:0] d);
        chk({name, " u0"}, 64'(r0), 64'({1'b1, err, d}));
        chk({name, " u1"}, 64'(r1), 64'({1'b1, err, d}));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " u0"}, 64'({u[0].bus.req_ready, u[0].bus.busy, u[0].bus.resp_valid, u[0].bus.resp_err, u[0].bus.resp_rdata}), 64'({1'b1, 35'h0}));
        chk({name, " u1"}, 64'({u[1].bus.req_ready, u[1].bus.busy, u[1].bus.resp_valid, u[1].bus.resp_err, u[1].bus.resp_rdata}), 64'({1'b1, 35'h0}));
    endtask

    initial begin
        int   last0, last1;
        logic seen;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk_reset_outputs("reset outputs");
        reset = 1'b0;
        req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk_resp("store 0x10", 1'b0, 32'h0);
        req(1'b0, 32'h10, 32'h0, 4'h0);
        chk_resp("load 0x10", 1'b0, 32'hDEADBEEF);
        chk("model word 4", 64'(u[0].mem[4]), 64'(32'hDEADBEEF));
        req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
        req(1'b0, 32'h10, 32'h0, 4'hF);
        chk_resp("byte store", 1'b0, 32'hDEADBEAA);
        req(1'b1, 32'h10, 32'h12345678, 4'b0000);
        chk_resp("be0 store", 1'b0, 32'h0);
        req(1'b0, 32'h10, 32'h0, 4'h0);
        chk_resp("be0 readback", 1'b0, 32'hDEADBEAA);
        req(1'b0, 32'h12, 32'h0, 4'h0);
        chk_resp("misaligned load", 1'b1, 32'h0);
        req(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
        chk_resp("range load", 1'b1, 32'h0);
        req(1'b1, 32'h11, 32'h0, 4'hF);
        chk_resp("misaligned store", 1'b1, 32'h0);
        req(1'b0, 32'h10, 32'h0, 4'h0);
        chk_resp("after errors", 1'b0, 32'hDEADBEAA);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= u[0].bus.resp_valid | u[1].bus.resp_valid;
        end
        chk("aborted response", 64'(seen), 64'(0));
        req(1'b0, 32'h20, 32'h0, 4'h0);
        chk_resp("aborted store", 1'b0, 32'h0);
        chk("model word 8", 64'(u[0].mem[8]), 64'(0));
        reset = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'hFFFFFFFF;
        req_be    = 4'hF;
        @(negedge clk);
        chk_reset_outputs("reset beats req");
        reset = 1'b0;
        req_valid = 1'b0;
        req(1'b0, 32'h0, 32'h0, 4'h0);
        chk_resp("reset beats req load", 1'b0, 32'h0);
        req_valid = 1'b1;
        last0 = -1;
        last1 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            scramble();
            if (u[0].bus.resp_valid) begin
                if (last0 >= 0) chk("spacing u0", 64'(i - last0), 64'(5));
                last0 = i;
            end
            if (u[1].bus.resp_valid) begin
                if (last1 >= 0) chk("spacing u1", 64'(i - last1), 64'(3));
                last1 = i;
            end
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 600; i++) begin
            reset = $urandom_range(0, 63) == 0;
            req_valid = 1'($urandom);
            scramble();
            @(negedge clk);
        end
        reset = 1'b0;
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("final reset");
        reset = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
